nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//  Sequencer that reuses one 4-bit ripple adder (four_bit_adder) to add or subtract WIDTH-bit operands,
//  one nibble per clock, LS nibble first. Area-cheap wide add for datapaths that tolerate multi-cycle latency.
//  Single requester, start/busy/done handshake; result registered and held until the next accepted start.
// PARAMETERS
//  WIDTH   16   operand/result width; multiple of 4, >= 4 (elaboration error otherwise)
//  NIB     WIDTH/4 (localparam) nibble count; CNT_W = max(1, $clog2(NIB)) (localparam)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request; sampled only when busy==0
//  sub     in   1      0: a+b+cin   1: a-b (b inverted, cin ignored, forced 1)
//  a       in   WIDTH  operand A, captured on accepted start
//  b       in   WIDTH  operand B, captured on accepted start
//  cin     in   1      carry-in for add, captured on accepted start
//  busy    out  1      1 while nibbles are being processed
//  done    out  1      one-cycle pulse: result valid
//  sum     out  WIDTH  result, held stable until next completion
//  cout    out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf     out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, index and all internal regs cleared.
//  - FSM: IDLE --start--> RUN; RUN --(idx==NIB-1)--> DONE; DONE --start--> RUN, else --> IDLE.
//  - Accept: edge E0 with busy==0 and start==1 captures a, b_eff = sub ? ~b : b, c = sub ? 1 : cin;
//    idx=0; busy=1 from E0. start while busy==1 is ignored (no queueing, no error).
//  - RUN, edge Ek (k=1..NIB): adder fed a_sh[3:0], b_sh[3:0], c; nibble result shifted into MSB end
//    of the accumulator; a_sh/b_sh shift right 4; c <= adder Cout; idx++.
//  - Completion at edge E_NIB: sum<=accumulator, cout<=final carry, ovf<=(a[W-1]==b_eff[W-1]) &&
//    (sum[W-1]!=a[W-1]); done=1 for exactly that one cycle; busy=0. Latency = NIB cycles start->done.
//  - sum/cout/ovf change only at completion edges; intermediate nibbles never visible on outputs.
//  - start during DONE cycle is accepted (busy==0): back-to-back ops, throughput one per NIB+1 cycles.
//  - Inputs a/b/sub/cin may change after E0 without effect on the running operation.
//  - rst mid-RUN: aborts, returns to reset state on that edge; no done pulse; sum cleared to 0.
//  - WIDTH==4: RUN lasts one cycle; done exactly one cycle after accept.
// STRUCTURE
//  - Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), NIBBLE_W=4 constant.
//  - One sub-module instance: four_bit_adder (existing 4-bit ripple adder), combinational, unmodified.
//  - Controller: FSM, idx counter, operand shift regs, carry reg, accumulator, output regs.
// TESTING (WIDTH=16 unless noted; latency checked on every op: done exactly 4 cycles after accept)
//  - add 0x1234+0x0FCD, cin=0 -> sum=0x2201, cout=0, ovf=0; done one cycle wide, busy low after.
//  - add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; add 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1.
//  - sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1; sub 0x0003-0x0005 -> 0xFFFE, cout=0, ovf=0.
//  - start pulsed every cycle during RUN with changing a/b -> ignored; result of first op unchanged;
//    start held in DONE cycle -> second op accepted, done again 4 cycles later.
//  - rst asserted at 2nd RUN cycle -> busy=0, sum=0, no done; next op completes correctly.
//  - WIDTH=4: 0x9+0x8, cin=1 -> sum=0x2, cout=1, ovf=1, done one cycle after accept.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// Combinational 4-bit ripple-carry adder reused once per nibble.
module four_bit_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic c;

   always_comb begin
      s = '0;
      c = cin;
      for (int i = 0; i < 4; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built from one 4-bit adder, one nibble per clock,
// least-significant nibble first; result held until the next completion.
module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   import nibble_serial_adder_ctrl_pkg::*;

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of 4 and at least 4");
   end

   state_t             state_q;
   state_t             state_d;
   logic               accept;
   logic               last;
   logic [CNT_W-1:0]   idx_q;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   acc_nx;
   logic               c_q;
   logic               a_msb;
   logic               b_msb;
   logic [3:0]         nib_s;
   logic               nib_c;

   four_bit_adder u_add (
      .a    (a_sh[3:0]),
      .b    (b_sh[3:0]),
      .cin  (c_q),
      .s    (nib_s),
      .cout (nib_c)
   );

   // New nibble enters at the top; after NIB shifts it lands in place.
   if (NIB == 1) begin : g_one
      assign acc_nx = nib_s;
   end else begin : g_many
      assign acc_nx = {nib_s, acc[WIDTH-1:NIBBLE_W]};
   end

   assign last = (idx_q == CNT_W'(NIB - 1));
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               accept  = 1'b1;
            end
         end
         RUN: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            if (start) begin
               state_d = RUN;
               accept  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         c_q   <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         idx_q <= '0;
         a_sh  <= a;
         b_sh  <= sub ? ~b : b;
         acc   <= '0;
         c_q   <= sub | cin;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1] ^ sub;
      end else if (state_q == RUN) begin
         idx_q <= idx_q + 1'b1;
         a_sh  <= a_sh >> NIBBLE_W;
         b_sh  <= b_sh >> NIBBLE_W;
         acc   <= acc_nx;
         c_q   <= nib_c;
         if (last) begin
            sum  <= acc_nx;
            cout <= nib_c;
            ovf  <= (a_msb == b_msb) && (nib_s[3] != a_msb);
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: 16-bit instance for the main ops, 4-bit instance for the narrow case.
module tb_nibble_serial_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   logic        start4 = 1'b0;
   logic        sub4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        cin4 = 1'b0;
   logic        busy4;
   logic        done4;
   logic [3:0]  sum4;
   logic        cout4;
   logic        ovf4;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        v;
      int          t;
   } exp_t;

   exp_t q[$];
   exp_t em;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic prev_done = 1'b0;

   nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .sub   (sub4),
      .a     (a4),
      .b     (b4),
      .cin   (cin4),
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4),
      .ovf   (ovf4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                  input logic isub, input logic icin);
      exp_t        r;
      logic [15:0] be;
      logic [16:0] full;
      be   = isub ? ~ib : ib;
      full = {1'b0, ia} + {1'b0, be} + {16'd0, (isub ? 1'b1 : icin)};
      r.s  = full[15:0];
      r.c  = full[16];
      r.v  = (ia[15] == be[15]) && (full[15] != ia[15]);
      r.t  = 0;
      return r;
   endfunction

   task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic icin);
      exp_t e;
      int   n;
      n = 0;
      while (busy && n < 50) begin
         cycle();
         n++;
      end
      if (busy) check("issue_timeout", 1, 0);
      a     = ia;
      b     = ib;
      sub   = isub;
      cin   = icin;
      start = 1'b1;
      e     = model(ia, ib, isub, icin);
      e.t   = cyc + 1;
      q.push_back(e);
      cycle();
      start = 1'b0;
      check("busy_after_accept", busy, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 100) begin
         cycle();
         n++;
      end
      check("drain_timeout", q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         check("done_single_cycle", prev_done, 0);
         check("busy_at_done", busy, 0);
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            em = q.pop_front();
            check("sum", sum, em.s);
            check("cout", cout, em.c);
            check("ovf", ovf, em.v);
            check("latency", cyc - em.t, 4);
         end
      end
      prev_done <= done;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rst = 1'b1;
      repeat (3) cycle();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy4", busy4, 0);
      check("rst_sum4", sum4, 0);
      rst = 1'b0;
      cycle();

      issue(16'h1234, 16'h0FCD, 1'b0, 1'b0);
      drain();
      cycle();
      check("busy_low_after", busy, 0);
      check("sum_held", sum, 16'h2201);
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      issue(16'h8000, 16'h0001, 1'b1, 1'b0);
      issue(16'h0003, 16'h0005, 1'b1, 1'b1);
      drain();

      // Requests during RUN must be dropped; the DONE-cycle request is taken.
      issue(16'h1111, 16'h2222, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         a     = 16'($urandom);
         b     = 16'($urandom);
         sub   = i[0];
         cin   = 1'b1;
         start = 1'b1;
         cycle();
      end
      check("done_at_back_to_back", done, 1);
      issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
      drain();

      // Abort in the second RUN cycle.
      issue(16'h4321, 16'h1111, 1'b0, 1'b0);
      cycle();
      rst = 1'b1;
      void'(q.pop_back());
      cycle();
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", sum, 0);
      rst = 1'b0;
      repeat (6) cycle();
      check("abort_no_done", done, 0);
      issue(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
      drain();

      for (int i = 0; i < 6; i++) begin
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      drain();

      a4     = 4'h9;
      b4     = 4'h8;
      cin4   = 1'b1;
      sub4   = 1'b0;
      start4 = 1'b1;
      cycle();
      start4 = 1'b0;
      check("w4_busy", busy4, 1);
      check("w4_done_early", done4, 0);
      cycle();
      check("w4_done", done4, 1);
      check("w4_sum", sum4, 4'h2);
      check("w4_cout", cout4, 1);
      check("w4_ovf", ovf4, 1);
      cycle();
      check("w4_done_gone", done4, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
